// File: rtl/halut_pkg.sv
// HALUT encoder shared definitions.
// Holds the width helper functions derived from K and the FSM state
// encoding used by halut_encoder_stream. Ports: none (package).
package halut_pkg;

  // Depth of the balanced decision tree for K prototypes.
  function automatic int unsigned tree_depth(input int unsigned k);
    return $clog2(k);
  endfunction

  // Width of the level counter; kept at least one bit so K=2 still works.
  function automatic int unsigned lvl_width(input int unsigned k);
    int unsigned depth;
    depth = $clog2(k);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRAVERSE = 2'd1,
    ST_HOLD     = 2'd2
  } state_e;

endpackage

// File: rtl/halut_encoder_stream_if.sv
// HALUT encoder stream bus.
// Groups the row input handshake, threshold write port and result output
// handshake of one encoder unit.
//   master : row source / threshold writer / result consumer
//   slave  : the encoder itself
interface halut_encoder_stream_if
  import halut_pkg::*;
#(
  parameter int unsigned K             = 16,
  parameter int unsigned C             = 32,
  parameter int unsigned EncUnits      = 4,
  parameter int unsigned DataTypeWidth = 16
);
  localparam int unsigned TreeDepth          = tree_depth(K);
  localparam int unsigned CAddrWidth         = $clog2(C);
  localparam int unsigned CPerEncUnit        = C / EncUnits;
  localparam int unsigned CCntWidth          = $clog2(CPerEncUnit);
  localparam int unsigned ThreshMemAddrWidth = CCntWidth + TreeDepth;

  logic                                    in_valid_i;
  logic                                    in_ready_o;
  logic [TreeDepth-1:0][DataTypeWidth-1:0] a_input_i;
  logic [ThreshMemAddrWidth-1:0]           waddr_i;
  logic [DataTypeWidth-1:0]                wdata_i;
  logic                                    we_i;
  logic                                    out_valid_o;
  logic                                    out_ready_i;
  logic [CAddrWidth-1:0]                   c_addr_o;
  logic [TreeDepth-1:0]                    k_addr_o;

  modport master (
    output in_valid_i, a_input_i, waddr_i, wdata_i, we_i, out_ready_i,
    input  in_ready_o, out_valid_o, c_addr_o, k_addr_o
  );

  modport slave (
    input  in_valid_i, a_input_i, waddr_i, wdata_i, we_i, out_ready_i,
    output in_ready_o, out_valid_o, c_addr_o, k_addr_o
  );
endinterface

// File: rtl/fp_16_comparision.sv
// Half-precision "greater than" comparator.
//   operand_a_i   : fp16 feature value
//   operand_b_i   : fp16 threshold
//   comparision_o : 1 when operand_a_i > operand_b_i
// +0 and -0 compare equal. NaNs are not special-cased.
module fp_16_comparision (
  input  logic [15:0] operand_a_i,
  input  logic [15:0] operand_b_i,
  output logic        comparision_o
);
  logic        w_sign_a;
  logic        w_sign_b;
  logic [14:0] w_mag_a;
  logic [14:0] w_mag_b;

  assign w_sign_a = operand_a_i[15];
  assign w_sign_b = operand_b_i[15];
  assign w_mag_a  = operand_a_i[14:0];
  assign w_mag_b  = operand_b_i[14:0];

  always_comb begin
    comparision_o = 1'b0;
    if ((w_mag_a == '0) && (w_mag_b == '0)) begin
      comparision_o = 1'b0;
    end else if (w_sign_a != w_sign_b) begin
      comparision_o = !w_sign_a;
    end else if (!w_sign_a) begin
      comparision_o = (w_mag_a > w_mag_b);
    end else begin
      // Both negative: smaller magnitude is the larger number.
      comparision_o = (w_mag_a < w_mag_b);
    end
  end
endmodule

// File: rtl/halut_thresh_mem.sv
// Threshold storage for one encoder unit.
// Flop array, one registered write port, one combinational read port.
// A read of the address being written returns the old value. Not reset.
//   i_clk, i_we, i_waddr, i_wdata : write port
//   i_raddr, o_rdata              : read port
module halut_thresh_mem #(
  parameter int unsigned Depth     = 128,
  parameter int unsigned AddrWidth = 7,
  parameter int unsigned DataWidth = 16
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [AddrWidth-1:0] i_waddr,
  input  logic [DataWidth-1:0] i_wdata,
  input  logic [AddrWidth-1:0] i_raddr,
  output logic [DataWidth-1:0] o_rdata
);
  logic [DataWidth-1:0] r_mem [Depth];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/halut_encoder_stream.sv
// HALUT streaming tree encoder (one encoder unit).
// Walks a depth-TreeDepth decision tree one level per cycle per accepted row,
// picks its codebooks round-robin and emits {c_addr, k_addr} on a
// valid/ready output with backpressure.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   bus (slave)   : row handshake, threshold write port, result handshake
//
// state    | meaning
// IDLE     | waiting for a row, in_ready high
// TRAVERSE | one tree level per cycle; last level emits or stalls
// HOLD     | finished result waiting for the output slot, in_ready low
module halut_encoder_stream
  import halut_pkg::*;
#(
  parameter int unsigned K             = 16,
  parameter int unsigned C             = 32,
  parameter int unsigned EncUnits      = 4,
  parameter int unsigned DataTypeWidth = 16,
  parameter int unsigned EncUnitNumber = 0
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  halut_encoder_stream_if.slave  bus
);
  localparam int unsigned TreeDepth          = tree_depth(K);
  localparam int unsigned LvlWidth           = lvl_width(K);
  localparam int unsigned CAddrWidth         = $clog2(C);
  localparam int unsigned CPerEncUnit        = C / EncUnits;
  localparam int unsigned CCntWidth          = $clog2(CPerEncUnit);
  localparam int unsigned ThreshMemAddrWidth = CCntWidth + TreeDepth;
  localparam int unsigned EncUnitOffset      = EncUnitNumber * CPerEncUnit;
  localparam logic [LvlWidth-1:0] LastLvl    = LvlWidth'(TreeDepth - 1);

  state_e                                  r_state;
  state_e                                  w_state_nxt;
  logic [TreeDepth-1:0][DataTypeWidth-1:0] r_row;
  logic [TreeDepth-1:0]                    r_k;
  logic [TreeDepth-1:0]                    w_k_nxt;
  logic [LvlWidth-1:0]                     r_lvl;
  logic [LvlWidth-1:0]                     w_lvl_nxt;
  logic [CCntWidth-1:0]                    r_c_cnt;
  logic                                    r_out_valid;
  logic [TreeDepth-1:0]                    r_k_addr;
  logic [CAddrWidth-1:0]                   r_c_addr;

  logic                          w_ready;
  logic                          w_ld_row;
  logic                          w_ld_out;
  logic [TreeDepth-1:0]          w_out_k;
  logic [TreeDepth-1:0]          w_node;
  logic [TreeDepth-1:0]          w_next_k;
  logic [ThreshMemAddrWidth-1:0] w_raddr;
  logic [DataTypeWidth-1:0]      w_thresh;
  logic                          w_bit;
  logic                          w_last;
  logic                          w_slot_free;

  // Level-order node index: first node of level lvl is 2^lvl - 1.
  assign w_node  = ((TreeDepth'(1) << r_lvl) - TreeDepth'(1)) + r_k;
  assign w_raddr = {r_c_cnt, w_node};

  halut_thresh_mem #(
    .Depth     (CPerEncUnit * K),
    .AddrWidth (ThreshMemAddrWidth),
    .DataWidth (DataTypeWidth)
  ) u_thresh_mem (
    .i_clk   (clk_i),
    .i_we    (bus.we_i),
    .i_waddr (bus.waddr_i),
    .i_wdata (bus.wdata_i),
    .i_raddr (w_raddr),
    .o_rdata (w_thresh)
  );

  fp_16_comparision u_cmp (
    .operand_a_i   (r_row[r_lvl]),
    .operand_b_i   (w_thresh),
    .comparision_o (w_bit)
  );

  if (TreeDepth > 1) begin : g_shift
    assign w_next_k = {r_k[TreeDepth-2:0], w_bit};
  end else begin : g_single
    assign w_next_k = w_bit;
  end

  assign w_last      = (r_lvl == LastLvl);
  assign w_slot_free = !r_out_valid || bus.out_ready_i;

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_ld_row    = 1'b0;
    w_ld_out    = 1'b0;
    w_out_k     = w_next_k;
    w_k_nxt     = r_k;
    w_lvl_nxt   = r_lvl;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.in_valid_i) begin
          w_ld_row    = 1'b1;
          w_k_nxt     = '0;
          w_lvl_nxt   = '0;
          w_state_nxt = ST_TRAVERSE;
        end
      end
      ST_TRAVERSE: begin
        if (!w_last) begin
          w_k_nxt   = w_next_k;
          w_lvl_nxt = r_lvl + LvlWidth'(1);
        end else if (w_slot_free) begin
          // Emit and, if a row is waiting, start it without a bubble.
          w_ld_out  = 1'b1;
          w_ready   = 1'b1;
          w_k_nxt   = '0;
          w_lvl_nxt = '0;
          if (bus.in_valid_i) begin
            w_ld_row    = 1'b1;
            w_state_nxt = ST_TRAVERSE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_k_nxt     = w_next_k;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready_i) begin
          w_ld_out    = 1'b1;
          w_out_k     = r_k;
          w_lvl_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_lvl       <= '0;
      r_c_cnt     <= '0;
      r_out_valid <= 1'b0;
      r_k_addr    <= '0;
      r_c_addr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_lvl   <= w_lvl_nxt;
      if (w_ld_out) begin
        r_out_valid <= 1'b1;
        r_k_addr    <= w_out_k;
        r_c_addr    <= CAddrWidth'(r_c_cnt) + CAddrWidth'(EncUnitOffset);
        // CPerEncUnit is a power of two, so the natural wrap is the modulo.
        r_c_cnt     <= r_c_cnt + CCntWidth'(1);
      end else if (bus.out_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Row data needs no reset: it is only read after a load.
  always_ff @(posedge clk_i) begin
    if (w_ld_row) begin
      r_row <= bus.a_input_i;
    end
  end

  // Gate with reset so an upstream source never sees an accept during reset.
  assign bus.in_ready_o  = w_ready && rst_ni;
  assign bus.out_valid_o = r_out_valid;
  assign bus.k_addr_o    = r_k_addr;
  assign bus.c_addr_o    = r_c_addr;
endmodule

// File: tb/tb_halut_encoder_stream.sv
// Directed bench for halut_encoder_stream (K=16, C=32, EncUnits=4, unit 2).
module tb_halut_encoder_stream;
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  always #5 clk_i = ~clk_i;

  halut_encoder_stream_if #(.K(16), .C(32), .EncUnits(4), .DataTypeWidth(16)) bus ();

  halut_encoder_stream #(
    .K(16), .C(32), .EncUnits(4), .DataTypeWidth(16), .EncUnitNumber(2)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [63:0] row_q [$];
  int acc_t [$];
  int got_k [$];
  int got_c [$];
  int got_t [$];

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] row4(input logic [15:0] l0, input logic [15:0] l1,
                                       input logic [15:0] l2, input logic [15:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic load_inputs();
    if (row_q.size() > 0) begin
      bus.in_valid_i = 1'b1;
      bus.a_input_i  = row_q[0];
    end else begin
      bus.in_valid_i = 1'b0;
    end
  endtask

  // Called at a negedge: samples handshakes, advances one clock.
  task automatic tick();
    bit acc;
    bit take;
    #1;
    acc  = bus.in_valid_i && bus.in_ready_o;
    take = bus.out_valid_o && bus.out_ready_i;
    if (take) begin
      got_k.push_back(int'(bus.k_addr_o));
      got_c.push_back(int'(bus.c_addr_o));
      got_t.push_back(cyc);
    end
    if (acc) acc_t.push_back(cyc);
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
    if (acc) void'(row_q.pop_front());
    load_inputs();
  endtask

  task automatic drain(input string tag, input int n, input int budget);
    int b;
    b = 0;
    while (got_k.size() < n && b < budget) begin
      tick();
      b++;
    end
    check_val({tag, "_count"}, got_k.size(), n);
  endtask

  task automatic check_res(input string tag, input int idx, input int ek, input int ec);
    int k;
    int c;
    k = -1;
    c = -1;
    if (idx < got_k.size()) begin
      k = got_k[idx];
      c = got_c[idx];
    end
    check_val($sformatf("%s%0d_k", tag, idx), k, ek);
    check_val($sformatf("%s%0d_c", tag, idx), c, ec);
  endtask

  task automatic clear_q();
    acc_t.delete();
    got_k.delete();
    got_c.delete();
    got_t.delete();
  endtask

  task automatic write_thr(input int addr, input logic [15:0] val);
    bus.we_i    = 1'b1;
    bus.waddr_i = 7'(addr);
    bus.wdata_i = val;
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
    bus.we_i = 1'b0;
  endtask

  task automatic write_all(input logic [15:0] val);
    for (int i = 0; i < 128; i++) write_thr(i, val);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stable_bad;
    bus.in_valid_i  = 1'b1;
    bus.a_input_i   = '0;
    bus.we_i        = 1'b0;
    bus.waddr_i     = '0;
    bus.wdata_i     = '0;
    bus.out_ready_i = 1'b1;
    rst_ni          = 1'b0;

    // Reset with a row offered.
    repeat (2) @(negedge clk_i);
    #1;
    check_val("rst_in_ready", int'(bus.in_ready_o), 0);
    check_val("rst_out_valid", int'(bus.out_valid_o), 0);
    check_val("rst_k_addr", int'(bus.k_addr_o), 0);
    check_val("rst_c_addr", int'(bus.c_addr_o), 0);
    @(negedge clk_i);
    rst_ni         = 1'b1;
    bus.in_valid_i = 1'b0;

    // Single row: thresholds 0, inputs 1.0 -> all right branches.
    write_all(16'h0000);
    clear_q();
    row_q.push_back(row4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00));
    load_inputs();
    drain("single", 1, 20);
    check_res("single", 0, 15, 16);
    if (got_t.size() > 0 && acc_t.size() > 0)
      check_val("single_latency", got_t[0] - acc_t[0] - 1, 4);
    tick();
    check_val("single_valid_clears", int'(bus.out_valid_o), 0);

    // Traversal path 1,0,1,0.
    write_all(16'h3C00);
    clear_q();
    row_q.push_back(row4(16'h4000, 16'h0000, 16'h4000, 16'h0000));
    load_inputs();
    drain("path", 1, 20);
    check_res("path", 0, 10, 17);

    // Same path, last level must use node 12 (threshold 4.0 > 3.0).
    write_thr(2 * 16 + 12, 16'h4400);
    clear_q();
    row_q.push_back(row4(16'h4000, 16'h0000, 16'h4000, 16'h4200));
    load_inputs();
    drain("node12", 1, 20);
    check_res("node12", 0, 10, 18);

    // Reset mid-traversal drops the row and restarts c_cnt.
    clear_q();
    row_q.push_back(row4(16'h4000, 16'h4000, 16'h4000, 16'h4000));
    load_inputs();
    repeat (3) tick();
    rst_ni = 1'b0;
    row_q.delete();
    load_inputs();
    repeat (2) tick();
    rst_ni = 1'b1;
    repeat (6) tick();
    check_val("midrst_results", got_k.size(), 0);
    check_val("midrst_out_valid", int'(bus.out_valid_o), 0);

    // Streaming: 10 back-to-back rows, alternating all-right / all-left.
    clear_q();
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) row_q.push_back(row4(16'h4000, 16'h4000, 16'h4000, 16'h4000));
      else            row_q.push_back(row4(16'h0000, 16'h0000, 16'h0000, 16'h0000));
    end
    load_inputs();
    drain("stream", 10, 80);
    for (int i = 0; i < 10; i++) begin
      check_res("stream", i, (i % 2 == 0) ? 15 : 0, 16 + (i % 8));
      if (i > 0 && i < got_t.size())
        check_val($sformatf("stream%0d_gap", i), got_t[i] - got_t[i-1], 4);
    end

    // Backpressure: consumer stalls 12 cycles with two rows offered.
    clear_q();
    bus.out_ready_i = 1'b0;
    row_q.push_back(row4(16'h4000, 16'h4000, 16'h4000, 16'h4000));
    row_q.push_back(row4(16'h0000, 16'h0000, 16'h0000, 16'h0000));
    load_inputs();
    stable_bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_valid_o && (bus.k_addr_o !== 4'd15 || bus.c_addr_o !== 5'd18))
        stable_bad++;
    end
    check_val("bp_unstable_cycles", stable_bad, 0);
    check_val("bp_out_valid", int'(bus.out_valid_o), 1);
    check_val("bp_k_addr", int'(bus.k_addr_o), 15);
    check_val("bp_c_addr", int'(bus.c_addr_o), 18);
    #1;
    check_val("bp_in_ready", int'(bus.in_ready_o), 0);
    check_val("bp_rows_left", row_q.size(), 0);
    bus.out_ready_i = 1'b1;
    drain("bp", 2, 20);
    check_res("bp", 0, 15, 18);
    check_res("bp", 1, 0, 19);

    // Write collision: node 0 of codebook 4 rewritten in the level-0 cycle.
    clear_q();
    row_q.push_back(row4(16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00));
    load_inputs();
    tick();
    bus.we_i    = 1'b1;
    bus.waddr_i = 7'(4 * 16);
    bus.wdata_i = 16'h4000;
    tick();
    bus.we_i = 1'b0;
    for (int i = 0; i < 8; i++) row_q.push_back(row4(16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00));
    load_inputs();
    drain("coll", 9, 100);
    check_res("coll", 0, 15, 20);
    for (int i = 1; i < 8; i++) check_res("coll", i, 15, 16 + ((4 + i) % 8));
    check_res("coll", 8, 7, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
